pipelined_multiplexer: RTL

Parametrised, registered N-way multiplexer with a valid/ready handshake and a 2-entry skid buffer. It is the next generation of the datapath mux family and lets the pipeline register a mux stage, for example ALU operand select or writeback select, without breaking back-pressure. Out-of-range select codes produce a defined DEFAULT_VALUE and an error flag instead of X.

---
 rtl/pipelined_multiplexer_if.sv | 24 ++
 rtl/pipelined_multiplexer.sv | 64 ++++++
 2 files changed

// File: rtl/pipelined_multiplexer_if.sv
// pipelined_multiplexer_if: beat-side and output-side handshake signals of the registered mux
interface pipelined_multiplexer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 5,
  parameter int SEL_WIDTH  = 3
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] IN_BUS;
  logic [SEL_WIDTH-1:0]             SELECT;
  logic                             IN_VALID;
  logic                             IN_READY;
  logic                             FLUSH;
  logic [DATA_WIDTH-1:0]            OUT;
  logic                             OUT_VALID;
  logic                             OUT_READY;
  logic                             SEL_ERROR;
  modport master (
    output IN_BUS, SELECT, IN_VALID, FLUSH, OUT_READY,
    input  IN_READY, OUT, OUT_VALID, SEL_ERROR
  );
  modport slave (
    input  IN_BUS, SELECT, IN_VALID, FLUSH, OUT_READY,
    output IN_READY, OUT, OUT_VALID, SEL_ERROR
  );
endinterface

// File: rtl/pipelined_multiplexer.sv
// pipelined_multiplexer: registered N-way mux with valid/ready and a 2-entry skid buffer.
// Optional MUX_ERR_COUNT_EN adds a saturating ERR_COUNT of accepted out-of-range selects.
module pipelined_multiplexer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_INPUTS    = 5,
  parameter int                    SEL_WIDTH     = 3,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input logic CLK,
  input logic RESET,
`ifdef MUX_ERR_COUNT_EN
  output logic [15:0] ERR_COUNT,
`endif
  pipelined_multiplexer_if.slave bus
);
  logic [DATA_WIDTH-1:0] sel_data, main_data, skid_data;
  logic sel_ok, main_err, main_valid, skid_err, skid_valid, acc;
  assign sel_ok = 32'(bus.SELECT) < NUM_INPUTS;
  always_comb begin
    sel_data = DEFAULT_VALUE;
    for (int k = 0; k < NUM_INPUTS; k++)
      if (32'(bus.SELECT) == k) sel_data = bus.IN_BUS[k*DATA_WIDTH +: DATA_WIDTH];
  end
  // a beat presented during FLUSH is dropped, so it is never an accept
  assign acc = bus.IN_VALID && !skid_valid && !bus.FLUSH;
  always_ff @(posedge CLK)
    if (RESET) begin
      main_data  <= '0;
      main_err   <= 1'b0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.FLUSH) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || bus.OUT_READY) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_err   <= skid_err;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= acc;
        if (acc) begin
          main_data <= sel_data;
          main_err  <= !sel_ok;
        end
      end
    end else if (acc) begin
      skid_data  <= sel_data;
      skid_err   <= !sel_ok;
      skid_valid <= 1'b1;
    end
`ifdef MUX_ERR_COUNT_EN
  always_ff @(posedge CLK)
    if (RESET) ERR_COUNT <= '0;
    else if (acc && !sel_ok && ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
`endif
  assign bus.OUT       = main_data;
  assign bus.SEL_ERROR = main_err;
  assign bus.OUT_VALID = main_valid;
  assign bus.IN_READY  = !skid_valid;
endmodule
